// File: rtl/police_car_sprite_renderer.sv
// police_car_sprite_renderer: scan position to sprite ROM address, colour-key test, 3-cycle pixel pipeline
// Optional horizontal mirroring is built only when POLICE_CAR_FLIP_EN is defined.
module police_car_sprite_renderer #(
    parameter int          SPR_W   = 56,
    parameter int          SPR_H   = 35,
    parameter logic [23:0] KEY_RGB = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        in_valid,
    input  logic        frame_start,
    input  logic        pos_load,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        flip,
    output logic [18:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic        out_valid,
    output logic        sprite_on,
    output logic [23:0] out_rgb
);
    logic [9:0]  sh_x, sh_y, act_x, act_y;
    logic        eff_flip;
    logic [10:0] x11, y11, ax11, ay11, dx, dy, col;
    logic        hit;
    logic [18:0] addr_d;
    logic        hit1, valid1, hit2, valid2;
    logic        opaque;

    // shadow position: captured whenever a new position is offered
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_x <= '0;
            sh_y <= '0;
        end else if (pos_load) begin
            sh_x <= pos_x;
            sh_y <= pos_y;
        end
    end

    // active position: committed only at frame start, bypassing shadow when loaded the same cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            act_x <= '0;
            act_y <= '0;
        end else if (frame_start) begin
            act_x <= pos_load ? pos_x : sh_x;
            act_y <= pos_load ? pos_y : sh_y;
        end
    end

`ifdef POLICE_CAR_FLIP_EN
    logic sh_flip, act_flip;

    // mirror flag follows the same shadow/active double buffering as the position
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_flip  <= 1'b0;
            act_flip <= 1'b0;
        end else begin
            if (pos_load)
                sh_flip <= flip;
            if (frame_start)
                act_flip <= pos_load ? flip : sh_flip;
        end
    end

    assign eff_flip = act_flip;
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign eff_flip    = 1'b0;
`endif

    // hit test and address generation in 11 bits so a car near the right edge clips instead of wrapping
    always_comb begin
        x11    = {1'b0, DrawX};
        y11    = {1'b0, DrawY};
        ax11   = {1'b0, act_x};
        ay11   = {1'b0, act_y};
        hit    = in_valid && (x11 >= ax11) && (x11 < ax11 + 11'(SPR_W))
                          && (y11 >= ay11) && (y11 < ay11 + 11'(SPR_H));
        dx     = x11 - ax11;
        dy     = y11 - ay11;
        col    = eff_flip ? 11'(SPR_W - 1) - dx : dx;
        addr_d = hit ? 19'(dy) * 19'(SPR_W) + 19'(col) : '0;
    end

    // stage 1: present the address to the ROM with its hit/valid tags
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            hit1     <= 1'b0;
            valid1   <= 1'b0;
        end else begin
            rom_addr <= addr_d;
            hit1     <= hit;
            valid1   <= in_valid;
        end
    end

    // stage 2: tags ride alongside the ROM's one-cycle read
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit2   <= 1'b0;
            valid2 <= 1'b0;
        end else begin
            hit2   <= hit1;
            valid2 <= valid1;
        end
    end

    assign opaque = hit2 && (rom_data != KEY_RGB);

    // stage 3: colour-key transparency and output register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            sprite_on <= 1'b0;
            out_rgb   <= '0;
        end else begin
            out_valid <= valid2;
            sprite_on <= opaque;
            out_rgb   <= opaque ? rom_data : '0;
        end
    end
endmodule

// File: tb/tb_police_car_sprite_renderer.sv
// tb_police_car_sprite_renderer: per-pixel reference model with cycle-by-cycle compare plus directed literal checks
module tb_police_car_sprite_renderer;
    localparam logic [23:0] KEY = 24'hFF00FF;
    logic        Clk = 0, Reset_n = 0;
    logic [9:0]  DrawX = 0, DrawY = 0, pos_x = 0, pos_y = 0;
    logic        in_valid = 0, frame_start = 0, pos_load = 0, flip = 0;
    logic [23:0] rom_data = 0;
    logic [18:0] rom_addr;
    logic        out_valid, sprite_on;
    logic [23:0] out_rgb;
    int n_chk = 0, n_pass = 0;

    police_car_sprite_renderer dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .in_valid(in_valid),
        .frame_start(frame_start), .pos_load(pos_load), .pos_x(pos_x), .pos_y(pos_y), .flip(flip),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .sprite_on(sprite_on),
        .out_rgb(out_rgb)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_f(input int a);
        return (a == 5) ? KEY : 24'h123456;
    endfunction

    // sprite ROM with one cycle of read latency
    always @(posedge Clk) rom_data <= rom_f(int'(rom_addr));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // -1 means the pixel misses the car
    function automatic int model_addr(input int x, input int y, input int v, input int ax, input int ay, input int af);
        if (!(v != 0 && x >= ax && x < ax + 56 && y >= ay && y < ay + 35)) return -1;
        return (y - ay) * 56 + ((af != 0) ? 55 - (x - ax) : (x - ax));
    endfunction

    int m_sx = 0, m_sy = 0, m_sf = 0, m_ax = 0, m_ay = 0, m_af = 0, cnt = 0, cur_a;
    int h_addr[64], h_val[64], h_on[64], h_rgb[64];
    assign cur_a = model_addr(int'(DrawX), int'(DrawY), int'(in_valid), m_ax, m_ay, m_af);

    // reference model: expected results per presented pixel, indexed by the edge that accepted it
    always @(posedge Clk) begin
        if (!Reset_n) begin
            m_sx <= 0; m_sy <= 0; m_sf <= 0; m_ax <= 0; m_ay <= 0; m_af <= 0;
            h_addr[cnt % 64] <= 0; h_val[cnt % 64] <= 0; h_on[cnt % 64] <= 0; h_rgb[cnt % 64] <= 0;
        end else begin
            if (pos_load) begin
                m_sx <= int'(pos_x); m_sy <= int'(pos_y);
`ifdef POLICE_CAR_FLIP_EN
                m_sf <= int'(flip);
`endif
            end
            if (frame_start) begin
                m_ax <= pos_load ? int'(pos_x) : m_sx;
                m_ay <= pos_load ? int'(pos_y) : m_sy;
`ifdef POLICE_CAR_FLIP_EN
                m_af <= pos_load ? int'(flip) : m_sf;
`endif
            end
            h_addr[cnt % 64] <= (cur_a < 0) ? 0 : cur_a;
            h_val[cnt % 64]  <= int'(in_valid);
            h_on[cnt % 64]   <= (cur_a >= 0 && rom_f(cur_a) != KEY) ? 1 : 0;
            h_rgb[cnt % 64]  <= (cur_a >= 0 && rom_f(cur_a) != KEY) ? int'(rom_f(cur_a)) : 0;
        end
        cnt <= cnt + 1;
    end

    // every-cycle compare: address one edge after the pixel, outputs three edges after
    always @(negedge Clk) begin
        chk("rom_addr", int'(rom_addr), (!Reset_n || cnt < 1) ? 0 : h_addr[(cnt - 1) % 64]);
        chk("out_valid", int'(out_valid), (!Reset_n || cnt < 3) ? 0 : h_val[(cnt - 3) % 64]);
        chk("sprite_on", int'(sprite_on), (!Reset_n || cnt < 3) ? 0 : h_on[(cnt - 3) % 64]);
        chk("out_rgb", int'(out_rgb), (!Reset_n || cnt < 3) ? 0 : h_rgb[(cnt - 3) % 64]);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic px(input int x, input int y);
        DrawX = 10'(x); DrawY = 10'(y); in_valid = 1;
        step();
    endtask

    task automatic idle();
        in_valid = 0;
        step();
    endtask

    task automatic load(input int x, input int y, input logic f, input logic fs);
        pos_x = 10'(x); pos_y = 10'(y); flip = f; pos_load = 1; frame_start = fs; in_valid = 0;
        step();
        pos_load = 0; frame_start = 0;
    endtask

    initial begin
        in_valid = 1;
        repeat (4) step();
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_on", int'(sprite_on), 0);
        chk("rst_rgb", int'(out_rgb), 0);
        Reset_n = 1;
        step(); chk("lat1_valid", int'(out_valid), 0);
        step(); chk("lat2_valid", int'(out_valid), 0);
        step(); chk("lat3_valid", int'(out_valid), 1);

        load(100, 50, 0, 0);
        frame_start = 1; step(); frame_start = 0;
        px(100, 50);  chk("addr_topleft", int'(rom_addr), 0);
        px(155, 84);  chk("addr_botright", int'(rom_addr), 1959);
        px(156, 84);  chk("addr_rightmiss", int'(rom_addr), 0);
        px(105, 50);
        px(106, 50);
        idle(); chk("key_on", int'(sprite_on), 0); chk("key_rgb", int'(out_rgb), 0); chk("key_valid", int'(out_valid), 1);
        idle(); chk("opaque_on", int'(sprite_on), 1); chk("opaque_rgb", int'(out_rgb), 24'h123456);

        load(100, 50, 1, 1);
        px(100, 51);
`ifdef POLICE_CAR_FLIP_EN
        chk("flip_addr", int'(rom_addr), 111);
`else
        chk("flip_addr", int'(rom_addr), 56);
`endif
        load(100, 50, 0, 1);

        load(300, 200, 0, 0);
        px(101, 50);  chk("shadow_hold", int'(rom_addr), 1);
        px(301, 200); chk("shadow_nohit", int'(rom_addr), 0);
        frame_start = 1; px(301, 200); frame_start = 0;
        chk("commit_edge_old", int'(rom_addr), 0);
        px(301, 200); chk("commit_new", int'(rom_addr), 1);
        load(500, 100, 0, 1);
        px(501, 100); chk("passthru", int'(rom_addr), 1);

        load(1000, 0, 0, 1);
        px(1023, 0);  chk("clip_addr", int'(rom_addr), 23);
        px(0, 0);     chk("clip_nowrap", int'(rom_addr), 0);
        idle(); idle();

        for (int f = 0; f < 2; f++) begin
            load(200, 300, f[0], 1);
            for (int y = 298; y < 337; y++)
                for (int x = 198; x < 258; x++) px(x, y);
        end
        idle(); idle(); idle();

        load(0, 0, 0, 1);
        px(3, 3); px(4, 3);
        Reset_n = 0; #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_addr", int'(rom_addr), 0);
        step(); step(); step();
        Reset_n = 1;
        idle(); idle(); idle(); idle();
        chk("post_rst_idle", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
